// File: rtl/param_table_sequencer.sv
// param_table_sequencer
// Streams the entries of the constant TABLE parameter onto a valid/ready
// output, one entry per transfer. Supports single or looping passes, abort,
// a done pulse and a modulo-256 completed-pass counter.
// Optional: define PARAM_SEQ_CHECKSUM_EN to add an XOR checksum output over
// all transferred entries of the current/most recent pass.
module param_table_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter logic [DEPTH-1:0][WIDTH-1:0] TABLE = {4'hA, 4'h9, 4'h6, 4'h3}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] out_idx,
  output logic                     busy,
  output logic                     done,
`ifdef PARAM_SEQ_CHECKSUM_EN
  output logic [WIDTH-1:0]         checksum,
`endif
  output logic [7:0]               pass_cnt
);

  localparam int IDXW = $clog2(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [7:0]       r_pass_cnt;
  // out_data must read 0 after reset even though TABLE[0] may be nonzero;
  // r_loaded gates the table lookup until the first accepted start.
  logic             r_loaded;
  logic [WIDTH-1:0] w_data;
  logic             w_xfer;
  logic             w_last;
  logic             w_start;

  assign w_xfer  = (r_state == S_RUN) & out_ready;
  assign w_last  = (r_idx == LAST_IDX);
  assign w_start = (r_state == S_IDLE) & start & ~abort;
  assign w_data  = r_loaded ? TABLE[r_idx] : '0;

  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign out_data  = w_data;
  assign out_idx   = r_idx;
  assign pass_cnt  = r_pass_cnt;

  // Next-state decode; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_RUN;
        S_RUN:   if (w_xfer && w_last && !loop_en) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Entry index: reload on start, advance on transfer, wrap when looping.
  // On a non-looping last transfer it holds so IDLE keeps showing the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_loaded <= 1'b0;
    end else if (w_start) begin
      r_idx    <= '0;
      r_loaded <= 1'b1;
    end else if (w_xfer && !abort) begin
      if (!w_last)     r_idx <= r_idx + IDXW'(1);
      else if (loop_en) r_idx <= '0;
    end
  end

  // Completed-pass counter; a pass finishing in the abort cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_pass_cnt <= 8'd0;
    else if (w_xfer && w_last) r_pass_cnt <= r_pass_cnt + 8'd1;
  end

`ifdef PARAM_SEQ_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;
  assign checksum = r_checksum;

  // XOR accumulation over every transferred entry since the last start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_xfer)  r_checksum <= r_checksum ^ w_data;
  end
`endif

endmodule

// File: tb/tb_param_table_sequencer.sv
// tb_param_table_sequencer: table-driven directed vectors for the sequencer
// plus hand-written sequences for pass_cnt wrap and async reset mid-pass.
module tb_param_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, loop_en = 1'b0, out_ready = 1'b0;
  logic       out_valid, busy, done;
  logic [3:0] out_data;
  logic [1:0] out_idx;
  logic [7:0] pass_cnt;
`ifdef PARAM_SEQ_CHECKSUM_EN
  logic [3:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_table_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done),
`ifdef PARAM_SEQ_CHECKSUM_EN
    .checksum(checksum),
`endif
    .pass_cnt(pass_cnt)
  );

  typedef struct {
    logic       st, ab, lp, rdy;
    logic       v, b, dn;
    logic [3:0] d;
    logic [1:0] i;
    logic [7:0] pc;
    logic       ce;
    logic [3:0] ck;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, ab, lp, rdy, v, b, dn,
                     input logic [3:0] d, input logic [1:0] i,
                     input logic [7:0] pc, input logic ce, input logic [3:0] ck);
    vec_t t;
    t.st = st; t.ab = ab; t.lp = lp; t.rdy = rdy;
    t.v = v; t.b = b; t.dn = dn; t.d = d; t.i = i; t.pc = pc;
    t.ce = ce; t.ck = ck;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int n, input logic v, b, dn,
                         input logic [3:0] d, input logic [1:0] i, input logic [7:0] pc);
    chk({nm, ".valid"}, n, 32'(out_valid), 32'(v));
    chk({nm, ".busy"},  n, 32'(busy),      32'(b));
    chk({nm, ".done"},  n, 32'(done),      32'(dn));
    chk({nm, ".data"},  n, 32'(out_data),  32'(d));
    chk({nm, ".idx"},   n, 32'(out_idx),   32'(i));
    chk({nm, ".pcnt"},  n, 32'(pass_cnt),  32'(pc));
  endtask

  // Drive inputs at negedge, sample 1ns after the following posedge
  task automatic step(input logic st, ab, lp, rdy);
    @(negedge clk);
    start = st; abort = ab; loop_en = lp; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset: start held high under reset has no effect
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst", 0, 0, 0, 0, 4'h0, 2'd0, 8'd0);
`ifdef PARAM_SEQ_CHECKSUM_EN
    chk("rst.cksum", 0, 32'(checksum), 32'h0);
`endif
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("post_rst", 0, 0, 0, 0, 4'h0, 2'd0, 8'd0);

    //  st ab lp rdy | v  b  dn  data idx pc | ce ck
    // single pass
    add(1,0,0,1, 1,1,0, 4'h3,2'd0,8'd0, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h6,2'd1,8'd0, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h9,2'd2,8'd0, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'hA,2'd3,8'd0, 0,4'h0);
    add(0,0,0,1, 0,0,1, 4'hA,2'd3,8'd1, 1,4'h6);
    add(0,0,0,1, 0,0,0, 4'hA,2'd3,8'd1, 1,4'h6);
    // backpressure at idx 1, then start during DONE is ignored
    add(1,0,0,1, 1,1,0, 4'h3,2'd0,8'd1, 1,4'h0);
    add(0,0,0,1, 1,1,0, 4'h6,2'd1,8'd1, 0,4'h0);
    add(0,0,0,0, 1,1,0, 4'h6,2'd1,8'd1, 0,4'h0);
    add(0,0,0,0, 1,1,0, 4'h6,2'd1,8'd1, 0,4'h0);
    add(0,0,0,0, 1,1,0, 4'h6,2'd1,8'd1, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h9,2'd2,8'd1, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'hA,2'd3,8'd1, 0,4'h0);
    add(0,0,0,1, 0,0,1, 4'hA,2'd3,8'd2, 1,4'h6);
    add(1,0,0,1, 0,0,0, 4'hA,2'd3,8'd2, 1,4'h6);
    add(0,0,0,1, 0,0,0, 4'hA,2'd3,8'd2, 1,4'h6);
    // looping: two passes, no bubble, extra starts ignored
    add(1,0,1,1, 1,1,0, 4'h3,2'd0,8'd2, 1,4'h0);
    add(1,0,1,1, 1,1,0, 4'h6,2'd1,8'd2, 0,4'h0);
    add(0,0,1,1, 1,1,0, 4'h9,2'd2,8'd2, 0,4'h0);
    add(0,0,1,1, 1,1,0, 4'hA,2'd3,8'd2, 0,4'h0);
    add(0,0,1,1, 1,1,0, 4'h3,2'd0,8'd3, 0,4'h0);
    add(1,0,0,1, 1,1,0, 4'h6,2'd1,8'd3, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h9,2'd2,8'd3, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'hA,2'd3,8'd3, 0,4'h0);
    add(0,0,0,1, 0,0,1, 4'hA,2'd3,8'd4, 1,4'h0);
    add(0,0,0,1, 0,0,0, 4'hA,2'd3,8'd4, 1,4'h0);
    // abort while stalled at idx 2, then abort+start in IDLE
    add(1,0,0,1, 1,1,0, 4'h3,2'd0,8'd4, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h6,2'd1,8'd4, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h9,2'd2,8'd4, 0,4'h0);
    add(0,0,0,0, 1,1,0, 4'h9,2'd2,8'd4, 0,4'h0);
    add(0,1,0,0, 0,0,0, 4'h9,2'd2,8'd4, 1,4'h5);
    add(1,1,0,1, 0,0,0, 4'h9,2'd2,8'd4, 1,4'h5);
    add(0,0,0,1, 0,0,0, 4'h9,2'd2,8'd4, 1,4'h5);
    // abort coinciding with the final transfer: pass still counts, no done
    add(1,0,0,1, 1,1,0, 4'h3,2'd0,8'd4, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h6,2'd1,8'd4, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'h9,2'd2,8'd4, 0,4'h0);
    add(0,0,0,1, 1,1,0, 4'hA,2'd3,8'd4, 0,4'h0);
    add(0,1,0,1, 0,0,0, 4'hA,2'd3,8'd5, 1,4'h6);
    add(0,0,0,1, 0,0,0, 4'hA,2'd3,8'd5, 0,4'h0);

    foreach (vq[k]) begin
      step(vq[k].st, vq[k].ab, vq[k].lp, vq[k].rdy);
      chk_all("vec", k, vq[k].v, vq[k].b, vq[k].dn, vq[k].d, vq[k].i, vq[k].pc);
`ifdef PARAM_SEQ_CHECKSUM_EN
      if (vq[k].ce) chk("vec.cksum", k, 32'(checksum), 32'(vq[k].ck));
`endif
    end

    // ---- pass_cnt wrap: loop from pc=5 through 255 and on to 0
    step(1, 0, 1, 1);
    repeat (4 * 250) step(0, 0, 1, 1);
    chk_all("wrap255", 0, 1, 1, 0, 4'h3, 2'd0, 8'd255);
    repeat (4) step(0, 0, 1, 1);
    chk_all("wrap0", 0, 1, 1, 0, 4'h3, 2'd0, 8'd0);
    step(0, 1, 0, 0);
    chk_all("wrap_abort", 0, 0, 0, 0, 4'h3, 2'd0, 8'd0);

    // ---- async reset between edges at idx 2
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("pre_arst", 0, 1, 1, 0, 4'h9, 2'd2, 8'd0);
    step(0, 0, 0, 1);
    chk_all("pre_arst2", 0, 1, 1, 0, 4'hA, 2'd3, 8'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("pass_cnt1", 0, 0, 0, 0, 4'hA, 2'd3, 8'd1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_all("run_idx2", 0, 1, 1, 0, 4'h9, 2'd2, 8'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, 4'h0, 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1);
    chk_all("arst_idle", 0, 0, 0, 0, 4'h0, 2'd0, 8'd0);
    step(1, 0, 0, 1);
    chk_all("restart", 0, 1, 1, 0, 4'h3, 2'd0, 8'd0);
    step(0, 0, 0, 1);
    chk_all("restart1", 0, 1, 1, 0, 4'h6, 2'd1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_table_sequencer.md
Name: param_table_sequencer

Overview:
Streams the entries of a compile-time parameter packed array (the constant lookup table) onto a valid/ready output, one entry per accepted transfer.
- Sequences single or looping passes over the table under start/abort control.
- Reports pass completion and a pass count.
- Sits between constant-table parameters and downstream consumers, e.g. test datapaths that previously drove table constants directly onto outputs.

Parameters:
WIDTH, 4, bit width of each table entry and of out_data
DEPTH, 4, number of table entries (>=2)
TABLE, {4'hA,4'h9,4'h6,4'h3}, packed array [DEPTH-1:0][WIDTH-1:0]; entry i is TABLE[i], so TABLE[0]=4'h3

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a pass; honoured only in IDLE
abort  input  1  terminate operation; highest priority
loop_en  input  1  sampled at last-entry transfer; 1 = restart at entry 0
out_valid  output  1  out_data/out_idx valid
out_ready  input  1  consumer accepts; transfer = out_valid & out_ready
out_data  output  WIDTH  TABLE[out_idx]
out_idx  output  $clog2(DEPTH)  current entry index
busy  output  1  high in RUN
done  output  1  one-cycle pulse after final transfer of a non-looping pass
pass_cnt  output  8  completed passes, modulo 256

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE; out_valid, out_data, out_idx, busy, done, pass_cnt all 0. Outputs go to 0 without waiting for a clock edge. Reset mid-pass discards the pass.
- States: IDLE, RUN, DONE.
- IDLE:
  - out_valid=0, busy=0.
  - start=1 and abort=0 -> RUN next cycle, out_idx=0, out_valid=1, out_data=TABLE[0]. Latency start->out_valid is 1 cycle.
- RUN:
  - busy=1, out_valid=1.
  - While out_valid & !out_ready: out_data and out_idx hold stable.
  - On a transfer with out_idx<DEPTH-1: out_idx increments and out_data=TABLE[out_idx+1] next cycle. No bubble, so one transfer per cycle is possible.
  - On a transfer with out_idx==DEPTH-1: pass_cnt increments (255 wraps to 0).
    - If loop_en=1 that cycle: stay in RUN, out_idx=0, no bubble.
    - Otherwise: go to DONE, out_valid=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally. start is ignored in DONE.
- abort=1 in any state -> IDLE next cycle.
  - out_valid=0 and done=0 in that next cycle.
  - pass_cnt is unchanged, except that a transfer completing the pass in the abort cycle still counts.
  - abort and start together in IDLE: abort wins and the block stays IDLE.
- start while busy: ignored, with no effect on out_idx.
- pass_cnt is cleared only by reset.
- out_data is combinational from TABLE indexed by the out_idx register. Indexing is always in range and has no X paths. In IDLE, out_data holds the last value.

Optional Feature:
Macro PARAM_SEQ_CHECKSUM_EN.
- Defined: adds output port checksum [WIDTH-1:0], reset 0.
  - Cleared to 0 on an accepted start.
  - XORed with out_data on every transfer.
  - Holds after done or abort until the next start.
- Undefined: the checksum port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, drive start=1 -> out_valid=0, busy=0, done=0, pass_cnt=0, out_idx=0. Release rst_n -> still IDLE until a start pulse.
- Single pass, out_ready=1, loop_en=0: start pulse -> out_data 3,6,9,A on cycles 1-4; done=1 on cycle 5 only; pass_cnt=1. With PARAM_SEQ_CHECKSUM_EN, checksum=4'h6.
- Backpressure: out_ready=0 for 3 cycles while out_idx=1 -> out_data stays 6 and out_idx stays 1. After release, sequence continues 9,A, then done.
- Looping: loop_en=1 for the first pass, 0 thereafter -> 8 transfers 3,6,9,A,3,6,9,A with no bubble; pass_cnt=2; exactly one done pulse. Extra start pulses during RUN have no effect.
- Abort: abort at out_idx=2 while a transfer is stalled -> next cycle out_valid=0, busy=0, no done, pass_cnt unchanged. abort+start together in IDLE -> remains IDLE.
- Async reset mid-run: drop rst_n between clock edges at out_idx=2 -> outputs 0 before the next edge. After release, a new start restarts at entry 0.
